barrel_shift_arm_pipe: RTL and testbench

Parametrised, two-stage pipelined ARM operand-2 barrel shifter with a valid/ready handshake on both sides. It supports both immediate-shift encoding (amount 0 special cases, RRX) and register-specified shifts (8-bit amount, amounts ≥ width), and passes a sideband tag alongside each operation. It sits between register read and the ALU in the datapath and sustains one operation per cycle when not stalled.

---
 rtl/barrel_shift_arm_pipe.sv | 260 ++++++++++++++++++++++++++
 tb/tb_barrel_shift_arm_pipe.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/barrel_shift_arm_pipe.sv
// ---------------------------------------------------------------------------
// barrel_shift_arm_pipe
//
// Two-stage pipelined ARM operand-2 barrel shifter with valid/ready on both
// sides. Handles the immediate-shift encoding (amount-0 special cases: LSR #32,
// ASR #32, RRX) and the register-specified encoding (8-bit amount, amounts at
// or beyond the operand width). A sideband tag travels with every operation.
//
// Stage 1 captures the operand, the effective amount, the opcode and a decoded
// result mode that folds every special case into a single selector.
// Stage 2 runs the log2(W)-level mux shifter, selects the carry and registers
// the result. No combinational path exists from in_* to out_*; only in_ready
// depends combinationally on out_ready.
//
// Ports
//   clk              clock, all state updates on the rising edge
//   rst              synchronous active-high reset
//   in_valid         request present
//   in_ready         block can accept this cycle
//   shift_in         operand x (DATA_WIDTH bits)
//   shift_amount     shift amount; immediate mode uses the low log2(W) bits
//   shift_op         0 = LSL, 1 = LSR, 2 = ASR, 3 = ROR
//   shift_reg        0 = immediate encoding, 1 = register encoding
//   carry_flag       current C flag, sampled when the request is accepted
//   in_tag           sideband tag, passed through unchanged
//   out_valid        result present
//   out_ready        consumer accepts the result
//   shift_out        shifted result
//   shift_carry_out  shifter carry out
//   out_tag          tag belonging to the result
// ---------------------------------------------------------------------------
module barrel_shift_arm_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] shift_in,
  input  logic [7:0]            shift_amount,
  input  logic [1:0]            shift_op,
  input  logic                  shift_reg,
  input  logic                  carry_flag,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] shift_out,
  output logic                  shift_carry_out,
  output logic [TAG_WIDTH-1:0]  out_tag
);

  localparam int AW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {
    OP_LSL = 2'd0,
    OP_LSR = 2'd1,
    OP_ASR = 2'd2,
    OP_ROR = 2'd3
  } shift_op_e;

  // Result mode chosen in stage 1. Only M_SHIFT uses the mux shifter; every
  // other mode is a fixed pattern derived from x and the captured C flag.
  typedef enum logic [2:0] {
    M_SHIFT     = 3'd0,  // real shift by 1..W-1
    M_PASS      = 3'd1,  // out = x,          C = carry_flag
    M_ZERO_LSB  = 3'd2,  // out = 0,          C = x[0]     (LSL #W)
    M_ZERO_MSB  = 3'd3,  // out = 0,          C = x[W-1]   (LSR #W)
    M_ZERO_NONE = 3'd4,  // out = 0,          C = 0        (LSL/LSR > W)
    M_SIGN      = 3'd5,  // out = sign fill,  C = x[W-1]   (ASR >= W)
    M_RRX       = 3'd6,  // out = {C, x>>1},  C = x[0]
    M_WRAP      = 3'd7   // out = x,          C = x[W-1]   (ROR by k*W)
  } mode_e;

  // -------------------------------------------------------------------------
  // Handshake control
  // -------------------------------------------------------------------------
  logic s1_valid;
  logic s2_valid;
  logic s1_load;
  logic s2_load;

  assign s2_load   = !s2_valid || out_ready;
  assign s1_load   = !s1_valid || s2_load;
  assign in_ready  = s1_load;
  assign out_valid = s2_valid;

  // -------------------------------------------------------------------------
  // Stage 1 decode
  // -------------------------------------------------------------------------
  logic [AW-1:0] amt_lo;     // amount modulo W
  logic [31:0]   amt_full;   // full register amount, widened for compares
  logic          amt_lt_w;
  logic          amt_eq_w;
  shift_op_e     dec_op;
  mode_e         dec_mode;

  assign amt_lo   = AW'(shift_amount);
  assign amt_full = 32'(shift_amount);
  assign amt_lt_w = amt_full < 32'(DATA_WIDTH);
  assign amt_eq_w = amt_full == 32'(DATA_WIDTH);
  assign dec_op   = shift_op_e'(shift_op);

  // NOTE: always_comb assigns every output a default before any branch, so no
  // path through the block leaves a signal unassigned and no latch is inferred.
  always_comb begin
    dec_mode = M_SHIFT;
    if (!shift_reg) begin
      // Immediate encoding: an amount of 0 re-purposes each opcode.
      if (amt_lo == '0) begin
        unique case (dec_op)
          OP_LSL: dec_mode = M_PASS;
          OP_LSR: dec_mode = M_ZERO_MSB;
          OP_ASR: dec_mode = M_SIGN;
          OP_ROR: dec_mode = M_RRX;
        endcase
      end
    end else if (shift_amount == 8'd0) begin
      dec_mode = M_PASS;
    end else begin
      unique case (dec_op)
        OP_LSL: begin
          if (!amt_lt_w) dec_mode = amt_eq_w ? M_ZERO_LSB : M_ZERO_NONE;
        end
        OP_LSR: begin
          if (!amt_lt_w) dec_mode = amt_eq_w ? M_ZERO_MSB : M_ZERO_NONE;
        end
        OP_ASR: begin
          if (!amt_lt_w) dec_mode = M_SIGN;
        end
        OP_ROR: begin
          // Rotation only depends on the amount modulo W.
          if (amt_lo == '0) dec_mode = M_WRAP;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Stage 1 registers
  // -------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] s1_x;
  logic [AW-1:0]         s1_amt;
  shift_op_e             s1_op;
  mode_e                 s1_mode;
  logic                  s1_cin;
  logic [TAG_WIDTH-1:0]  s1_tag;

  // NOTE: payload registers carry no reset; they are only observed while the
  // matching valid bit is set, and keeping them reset-free leaves reset off
  // their enable path.
  always_ff @(posedge clk) begin
    if (s1_load && in_valid) begin
      s1_x    <= shift_in;
      s1_amt  <= amt_lo;
      s1_op   <= dec_op;
      s1_mode <= dec_mode;
      s1_cin  <= carry_flag;
      s1_tag  <= in_tag;
    end
  end

  // -------------------------------------------------------------------------
  // Stage 2 datapath: log2(W) mux levels, level i shifts by 2**i
  // -------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] rot;
  logic [AW-1:0]         idx_left;
  logic [AW-1:0]         idx_right;
  logic                  shift_carry;

  // NOTE: combinational blocks chain intermediate values with blocking '=';
  // each mux level reads the previous level's result in the same evaluation.
  always_comb begin
    rot = s1_x;
    for (int i = 0; i < AW; i++) begin
      if (s1_amt[i]) begin
        unique case (s1_op)
          OP_LSL: rot = rot << (1 << i);
          OP_LSR: rot = rot >> (1 << i);
          OP_ASR: rot = $signed(rot) >>> (1 << i);
          OP_ROR: rot = (rot >> (1 << i)) | (rot << (DATA_WIDTH - (1 << i)));
        endcase
      end
    end
  end

  // Last bit shifted out: x[W-n] for LSL, x[n-1] for the right shifts. With
  // 1 <= n < W, W-n modulo 2**AW is simply -n in AW bits.
  assign idx_left    = AW'(0) - s1_amt;
  assign idx_right   = s1_amt - AW'(1);
  assign shift_carry = (s1_op == OP_LSL) ? s1_x[idx_left] : s1_x[idx_right];

  logic [DATA_WIDTH-1:0] res_data;
  logic                  res_carry;

  always_comb begin
    res_data  = rot;
    res_carry = shift_carry;
    unique case (s1_mode)
      M_SHIFT: begin
        res_data  = rot;
        res_carry = shift_carry;
      end
      M_PASS: begin
        res_data  = s1_x;
        res_carry = s1_cin;
      end
      M_ZERO_LSB: begin
        res_data  = '0;
        res_carry = s1_x[0];
      end
      M_ZERO_MSB: begin
        res_data  = '0;
        res_carry = s1_x[DATA_WIDTH-1];
      end
      M_ZERO_NONE: begin
        res_data  = '0;
        res_carry = 1'b0;
      end
      M_SIGN: begin
        res_data  = {DATA_WIDTH{s1_x[DATA_WIDTH-1]}};
        res_carry = s1_x[DATA_WIDTH-1];
      end
      M_RRX: begin
        res_data  = {s1_cin, s1_x[DATA_WIDTH-1:1]};
        res_carry = s1_x[0];
      end
      M_WRAP: begin
        res_data  = s1_x;
        res_carry = s1_x[DATA_WIDTH-1];
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Valid bits and stage 2 output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid        <= 1'b0;
      s2_valid        <= 1'b0;
      shift_out       <= '0;
      shift_carry_out <= 1'b0;
      out_tag         <= '0;
    end else begin
      if (s1_load) s1_valid <= in_valid;
      if (s2_load) begin
        s2_valid <= s1_valid;
        // Outputs only change when a real operation moves in, so an empty
        // stage 2 keeps showing the last result instead of stage 1 garbage.
        if (s1_valid) begin
          shift_out       <= res_data;
          shift_carry_out <= res_carry;
          out_tag         <= s1_tag;
        end
      end
    end
  end

endmodule

// File: tb/tb_barrel_shift_arm_pipe.sv
// ---------------------------------------------------------------------------
// Testbench for barrel_shift_arm_pipe. Drives a W=32 instance through
// directed vectors, streaming, backpressure, reset and random traffic, and a
// W=8 instance through boundary vectors and random single operations.
// ---------------------------------------------------------------------------
module tb_barrel_shift_arm_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // W = 32 instance
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] shift_in = '0;
  logic [7:0]  shift_amount = '0;
  logic [1:0]  shift_op = '0;
  logic        shift_reg = 1'b0;
  logic        carry_flag = 1'b0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] shift_out;
  logic        shift_carry_out;
  logic [3:0]  out_tag;

  barrel_shift_arm_pipe #(.DATA_WIDTH(32), .TAG_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .shift_in(shift_in), .shift_amount(shift_amount), .shift_op(shift_op),
    .shift_reg(shift_reg), .carry_flag(carry_flag), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .shift_out(shift_out), .shift_carry_out(shift_carry_out), .out_tag(out_tag)
  );

  // W = 8 instance
  logic       iv8 = 1'b0;
  logic       ir8;
  logic [7:0] x8 = '0;
  logic [7:0] amt8 = '0;
  logic [1:0] op8 = '0;
  logic       rm8 = 1'b0;
  logic       cf8 = 1'b0;
  logic [3:0] tin8 = '0;
  logic       ov8;
  logic       ordy8 = 1'b0;
  logic [7:0] so8;
  logic       co8;
  logic [3:0] tout8;

  barrel_shift_arm_pipe #(.DATA_WIDTH(8), .TAG_WIDTH(4)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(iv8), .in_ready(ir8),
    .shift_in(x8), .shift_amount(amt8), .shift_op(op8),
    .shift_reg(rm8), .carry_flag(cf8), .in_tag(tin8),
    .out_valid(ov8), .out_ready(ordy8),
    .shift_out(so8), .shift_carry_out(co8), .out_tag(tout8)
  );

  typedef struct {
    string       name;
    logic [31:0] x;
    logic [7:0]  amt;
    logic [1:0]  op;
    logic        rm;
    logic        cin;
    logic [31:0] eo;
    logic        ec;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] out;
    logic        c;
    logic [3:0]  tag;
  } exp_t;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb[$];

  logic        stalled_prev = 1'b0;
  logic [31:0] held_out;
  logic        held_c;
  logic [3:0]  held_tag;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Reference model straight from the ARM operand-2 rules, using plain
  // integer arithmetic on a w-bit value. Returns {carry, result}.
  function automatic logic [32:0] ref_shift(int w, logic [31:0] x, logic [7:0] amt,
                                            logic [1:0] op, logic rm, logic cin);
    longint unsigned mask = (64'd1 << w) - 64'd1;
    longint unsigned xv   = 64'(x) & mask;
    longint unsigned msb  = (xv >> (w - 1)) & 64'd1;
    longint unsigned o    = 0;
    longint unsigned c    = 0;
    int n = rm ? int'(amt) : int'(amt) % w;
    int r;
    if (n == 0 && (rm || op == 2'd0)) begin
      o = xv; c = 64'(cin);
    end else begin
      case (op)
        2'd0: begin
          if (n < w)       begin o = (xv << n) & mask; c = (xv >> (w - n)) & 64'd1; end
          else if (n == w) begin o = 0; c = xv & 64'd1; end
          else             begin o = 0; c = 0; end
        end
        2'd1: begin
          if (n == 0) n = w;
          if (n < w)       begin o = xv >> n; c = (xv >> (n - 1)) & 64'd1; end
          else if (n == w) begin o = 0; c = msb; end
          else             begin o = 0; c = 0; end
        end
        2'd2: begin
          if (n == 0) n = w;
          if (n >= w) begin o = (msb != 0) ? mask : 0; c = msb; end
          else begin
            o = (xv >> n) | ((msb != 0) ? (mask & ~(mask >> n)) : 64'd0);
            c = (xv >> (n - 1)) & 64'd1;
          end
        end
        default: begin
          if (!rm && n == 0) begin
            o = (64'(cin) << (w - 1)) | (xv >> 1); c = xv & 64'd1;
          end else begin
            r = n % w;
            if (r == 0) begin o = xv; c = msb; end
            else begin
              o = ((xv >> r) | (xv << (w - r))) & mask;
              c = (o >> (w - 1)) & 64'd1;
            end
          end
        end
      endcase
    end
    return {c[0], o[31:0]};
  endfunction

  function automatic vec_t rand_vec(int w, string name);
    vec_t v;
    logic [32:0] r;
    int sel = $urandom_range(0, 7);
    v.name = name;
    v.x    = $urandom;
    case (sel)
      0: v.amt = 8'd0;
      1: v.amt = 8'(w - 1);
      2: v.amt = 8'(w);
      3: v.amt = 8'(w + 1);
      4: v.amt = 8'(2 * w);
      5: v.amt = 8'd255;
      default: v.amt = 8'($urandom);
    endcase
    v.op  = 2'($urandom_range(0, 3));
    v.rm  = 1'($urandom_range(0, 1));
    v.cin = 1'($urandom_range(0, 1));
    r = ref_shift(w, v.x, v.amt, v.op, v.rm, v.cin);
    v.eo = r[31:0];
    v.ec = r[32];
    return v;
  endfunction

  // One cycle on the W=32 instance. Called at a falling edge; drives inputs,
  // evaluates both handshakes just before the rising edge, returns at the
  // next falling edge.
  task automatic step(input bit iv, input vec_t v, input logic [3:0] tag,
                      input bit ordy, output bit acc, output bit emit);
    exp_t e;
    in_valid     = iv;
    shift_in     = v.x;
    shift_amount = v.amt;
    shift_op     = v.op;
    shift_reg    = v.rm;
    carry_flag   = v.cin;
    in_tag       = tag;
    out_ready    = ordy;
    #1;
    if (stalled_prev) begin
      check("stall_hold_data", shift_out, held_out);
      check("stall_hold_carry", shift_carry_out, held_c);
      check("stall_hold_tag", out_tag, held_tag);
    end
    emit = out_valid && out_ready;
    if (emit) begin
      if (sb.size() == 0) check("spurious_out_valid", out_valid, 0);
      else begin
        e = sb.pop_front();
        check({e.name, "_data"}, shift_out, e.out);
        check({e.name, "_carry"}, shift_carry_out, e.c);
        check({e.name, "_tag"}, out_tag, e.tag);
      end
    end
    stalled_prev = out_valid && !out_ready;
    held_out     = shift_out;
    held_c       = shift_carry_out;
    held_tag     = out_tag;
    acc = iv && in_ready;
    if (acc) begin
      e.name = v.name; e.out = v.eo; e.c = v.ec; e.tag = tag;
      sb.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic send(input vec_t v, input logic [3:0] tag);
    bit acc, emit;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) step(1'b1, v, tag, 1'b1, acc, emit);
    if (!acc) check("send_timeout", acc, 1);
  endtask

  task automatic drain();
    bit acc, emit;
    vec_t idle;
    idle = '{name: "idle", x: '0, amt: '0, op: '0, rm: 1'b0, cin: 1'b0, eo: '0, ec: 1'b0};
    for (int i = 0; i < 20 && sb.size() != 0; i++) step(1'b0, idle, 4'd0, 1'b1, acc, emit);
    check("drain_empty", sb.size(), 0);
  endtask

  // Single operation on the W=8 instance, expected values supplied by caller.
  task automatic run8(input vec_t v);
    int t;
    iv8 = 1'b1; x8 = v.x[7:0]; amt8 = v.amt; op8 = v.op; rm8 = v.rm;
    cf8 = v.cin; tin8 = 4'hA; ordy8 = 1'b1;
    #1;
    check({v.name, "_w8_ready"}, ir8, 1);
    @(negedge clk);
    iv8 = 1'b0;
    t = 0;
    while (t < 4 && !ov8) begin
      @(negedge clk);
      t++;
    end
    if (!ov8) check({v.name, "_w8_timeout"}, ov8, 1);
    else begin
      check({v.name, "_w8_latency"}, t, 1);
      check({v.name, "_w8_data"}, so8, v.eo[7:0]);
      check({v.name, "_w8_carry"}, co8, v.ec);
      check({v.name, "_w8_tag"}, tout8, 4'hA);
    end
    @(negedge clk);
  endtask

  vec_t tbl32[16];
  vec_t tbl8[10];

  initial begin
    bit acc, emit;
    vec_t v, idle;
    vec_t bp_ops[3];
    int k, emits, c;
    bit pending;
    logic [3:0] tg;

    idle = '{name: "idle", x: '0, amt: '0, op: '0, rm: 1'b0, cin: 1'b0, eo: '0, ec: 1'b0};

    //              name        x             amt    op  rm  cin  exp_out       exp_c
    tbl32[0]  = '{"lsl_i4",    32'h12345678, 8'd4,  0, 0, 0, 32'h23456780, 1};
    tbl32[1]  = '{"lsr_i3",    32'h12345678, 8'd3,  1, 0, 0, 32'h02468ACF, 0};
    tbl32[2]  = '{"lsr_i0",    32'h12345678, 8'd0,  1, 0, 1, 32'h00000000, 0};
    tbl32[3]  = '{"asr_i2",    32'hF2345678, 8'd2,  2, 0, 0, 32'hFC8D159E, 0};
    tbl32[4]  = '{"asr_i0",    32'hF2345678, 8'd0,  2, 0, 0, 32'hFFFFFFFF, 1};
    tbl32[5]  = '{"rrx_c1",    32'hF2345678, 8'd0,  3, 0, 1, 32'hF91A2B3C, 0};
    tbl32[6]  = '{"rrx_c0",    32'hF2345678, 8'd0,  3, 0, 0, 32'h791A2B3C, 0};
    tbl32[7]  = '{"lsl_r32",   32'h80000001, 8'd32, 0, 1, 0, 32'h00000000, 1};
    tbl32[8]  = '{"lsl_r33",   32'h80000001, 8'd33, 0, 1, 1, 32'h00000000, 0};
    tbl32[9]  = '{"lsr_r32",   32'h80000001, 8'd32, 1, 1, 0, 32'h00000000, 1};
    tbl32[10] = '{"ror_r64",   32'h80000001, 8'd64, 3, 1, 0, 32'h80000001, 1};
    tbl32[11] = '{"ror_r33",   32'h80000001, 8'd33, 3, 1, 0, 32'hC0000000, 1};
    tbl32[12] = '{"lsl_r0",    32'h80000001, 8'd0,  0, 1, 0, 32'h80000001, 0};
    tbl32[13] = '{"lsl_i32",   32'h12345678, 8'd32, 0, 0, 1, 32'h12345678, 1};
    tbl32[14] = '{"asr_r40",   32'h80000001, 8'd40, 2, 1, 0, 32'hFFFFFFFF, 1};
    tbl32[15] = '{"lsl_i1",    32'h80000001, 8'd1,  0, 0, 0, 32'h00000002, 1};

    tbl8[0] = '{"lsl_r8",  32'h01, 8'd8,   0, 1, 0, 32'h00, 1};
    tbl8[1] = '{"lsl_r9",  32'h01, 8'd9,   0, 1, 1, 32'h00, 0};
    tbl8[2] = '{"lsr_r8",  32'h80, 8'd8,   1, 1, 0, 32'h00, 1};
    tbl8[3] = '{"ror_r16", 32'h81, 8'd16,  3, 1, 0, 32'h81, 1};
    tbl8[4] = '{"ror_r9",  32'h81, 8'd9,   3, 1, 0, 32'hC0, 1};
    tbl8[5] = '{"lsr_i0",  32'h80, 8'd0,   1, 0, 0, 32'h00, 1};
    tbl8[6] = '{"asr_i0",  32'h80, 8'd0,   2, 0, 0, 32'hFF, 1};
    tbl8[7] = '{"rrx_c1",  32'h02, 8'd0,   3, 0, 1, 32'h81, 0};
    tbl8[8] = '{"lsl_i8",  32'h5A, 8'd8,   0, 0, 1, 32'h5A, 1};
    tbl8[9] = '{"asr_r200",32'h40, 8'd200, 2, 1, 1, 32'h00, 0};

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_shift_out", shift_out, 0);
    check("reset_carry", shift_carry_out, 0);
    check("reset_tag", out_tag, 0);
    check("reset_w8_out_valid", ov8, 0);
    @(negedge clk);

    // Directed vectors, issued back to back
    foreach (tbl32[i]) send(tbl32[i], 4'(i));
    drain();

    // Streaming: 8 ops, one result per cycle, first two edges after accept
    emits = 0;
    for (c = 0; c < 12; c++) begin
      v = rand_vec(32, "stream");
      step(c < 8, v, 4'(c), 1'b1, acc, emit);
      if (c < 8) check("stream_accept", acc, 1);
      if (emit) begin
        check("stream_latency", c, emits + 2);
        emits++;
      end
    end
    check("stream_count", emits, 8);
    drain();

    // Backpressure: 3 ops offered while the consumer stalls for 4 cycles
    foreach (bp_ops[i]) bp_ops[i] = rand_vec(32, "bp");
    k = 0;
    for (c = 0; c < 4; c++) begin
      step(k < 3, bp_ops[k < 3 ? k : 2], 4'(8 + k), 1'b0, acc, emit);
      if (acc) k++;
    end
    check("bp_accepted", k, 2);
    check("bp_in_ready_low", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    emits = 0;
    for (c = 0; c < 10 && (k < 3 || sb.size() != 0); c++) begin
      step(k < 3, bp_ops[k < 3 ? k : 2], 4'(8 + k), 1'b1, acc, emit);
      if (acc) k++;
      if (emit) emits++;
    end
    check("bp_all_accepted", k, 3);
    check("bp_emitted", emits, 3);
    drain();

    // Reset with two operations in flight
    step(1'b1, rand_vec(32, "rst_a"), 4'd1, 1'b0, acc, emit);
    check("rst_a_accept", acc, 1);
    step(1'b1, rand_vec(32, "rst_b"), 4'd2, 1'b0, acc, emit);
    check("rst_b_accept", acc, 1);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_in_ready", in_ready, 1);
    check("rst_mid_shift_out", shift_out, 0);
    sb.delete();
    stalled_prev = 1'b0;
    emits = 0;
    for (c = 0; c < 3; c++) begin
      step(1'b0, idle, 4'd0, 1'b1, acc, emit);
      if (emit) emits++;
    end
    check("rst_no_stale", emits, 0);
    send(tbl32[11], 4'd5);
    drain();

    // Random traffic with random backpressure against the model
    pending = 1'b0;
    tg = 4'd0;
    for (c = 0; c < 400; c++) begin
      if (!pending) begin
        v = rand_vec(32, "rand");
        pending = 1'b1;
        tg = tg + 4'd1;
      end
      step(pending && ($urandom_range(0, 4) != 0), v, tg,
           $urandom_range(0, 3) != 0, acc, emit);
      if (acc) pending = 1'b0;
    end
    drain();

    // W = 8 boundary table and random single operations
    foreach (tbl8[i]) run8(tbl8[i]);
    for (int i = 0; i < 40; i++) run8(rand_vec(8, "rand8"));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
